// File: rtl/niveles_pkg.sv
// Shared types for the tank-level path: debounce FSM states and the 2-bit A/P codes.
package niveles_pkg;

  localparam int unsigned CODE_W = 2;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } deb_state_e;

  // Level sensor codes (A)
  localparam logic [CODE_W-1:0] A_EMPTY = 2'b00;
  localparam logic [CODE_W-1:0] A_LOW   = 2'b01;
  localparam logic [CODE_W-1:0] A_HIGH  = 2'b10;
  localparam logic [CODE_W-1:0] A_FULL  = 2'b11;

  // Pressure sensor codes (P)
  localparam logic [CODE_W-1:0] P_NORMAL  = 2'b00;
  localparam logic [CODE_W-1:0] P_LOW     = 2'b01;
  localparam logic [CODE_W-1:0] P_HIGH    = 2'b10;
  localparam logic [CODE_W-1:0] P_INVALID = 2'b11;

endpackage

// File: rtl/debounce_word.sv
// One debounced channel: word-wide 2-flop synchroniser, candidate/count FSM and,
// with SENSOR_CHATTER_FAULT_EN defined, a sticky chatter detector.
module debounce_word
  import niveles_pkg::*;
#(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CHATTER_CYCLES  = 1024,
  parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] word,
  output logic             commit,
  output logic             fault
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;
  deb_state_e       state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1     <= '0;
      s2     <= '0;
      cand   <= '0;
      cnt    <= '0;
      state  <= STABLE;
      word   <= RESET_WORD;
      commit <= 1'b0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      commit <= 1'b0;
      case (state)
        STABLE: begin
          if (s2 != word) begin
            state <= PENDING;
            cand  <= s2;
            cnt   <= CNT_W'(1);
          end
        end
        PENDING: begin
          if (s2 == word) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (s2 != cand) begin
            cand <= s2;
            cnt  <= CNT_W'(1);
          end else if (cnt == CNT_LAST) begin
            word   <= cand;
            commit <= 1'b1;
            state  <= STABLE;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= STABLE;
      endcase
    end
  end

`ifdef SENSOR_CHATTER_FAULT_EN
  localparam int unsigned CHAT_W = $clog2(CHATTER_CYCLES + 1);
  localparam logic [CHAT_W-1:0] CHAT_MAX = CHAT_W'(CHATTER_CYCLES);

  logic [CHAT_W-1:0] chat;
  logic              stay_pending_c;

  // True when this edge leaves the channel still unsettled in PENDING
  assign stay_pending_c = (state == PENDING) && (s2 != word) &&
                          !((s2 == cand) && (cnt == CNT_LAST));

  always_ff @(posedge clk) begin
    if (!reset) begin
      chat  <= '0;
      fault <= 1'b0;
    end else if (stay_pending_c) begin
      if (chat != CHAT_MAX) chat <= chat + CHAT_W'(1);
      if (chat == CHAT_MAX - CHAT_W'(1)) fault <= 1'b1;
    end else begin
      chat <= '0;
    end
  end
`else
  // No chatter detection built; CHATTER_CYCLES is always non-zero so this is constant low
  assign fault = (CHATTER_CYCLES == 0);
`endif

endmodule

// File: rtl/sensor_debounce.sv
// Debounces the raw A (level) and P (pressure) switch words for the level FSM.
// Optional chatter fault enabled by defining SENSOR_CHATTER_FAULT_EN.
module sensor_debounce
  import niveles_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CHATTER_CYCLES  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] A_raw,
  input  logic [CODE_W-1:0] P_raw,
  output logic [CODE_W-1:0] A,
  output logic [CODE_W-1:0] P,
  output logic              upd,
  output logic              fault
);

  logic a_commit;
  logic p_commit;
  logic a_fault;
  logic p_fault;

  debounce_word #(
    .WIDTH          (CODE_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CHATTER_CYCLES (CHATTER_CYCLES),
    .RESET_WORD     (A_EMPTY)
  ) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .raw   (A_raw),
    .word  (A),
    .commit(a_commit),
    .fault (a_fault)
  );

  debounce_word #(
    .WIDTH          (CODE_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CHATTER_CYCLES (CHATTER_CYCLES),
    .RESET_WORD     (P_NORMAL)
  ) u_deb_p (
    .clk   (clk),
    .reset (reset),
    .raw   (P_raw),
    .word  (P),
    .commit(p_commit),
    .fault (p_fault)
  );

  // Both inputs are flop outputs, so a simultaneous commit still gives one pulse
  assign upd   = a_commit | p_commit;
  assign fault = a_fault | p_fault;

endmodule

// File: tb/tb_sensor_debounce.sv
// Scoreboard bench for sensor_debounce: run-length reference model predicts commits,
// a negedge monitor pops and compares on every upd.
module tb_sensor_debounce;

  localparam int unsigned DEB  = 4;
  localparam int unsigned CHAT = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] A_raw;
  logic [1:0] P_raw;
  logic [1:0] A;
  logic [1:0] P;
  logic       upd;
  logic       fault;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .CHATTER_CYCLES (CHAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .A_raw(A_raw),
    .P_raw(P_raw),
    .A    (A),
    .P    (P),
    .upd  (upd),
    .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  a;
    logic [1:0]  p;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned cyc    = 0;

  // Reference model: a word is committed once the synchronised stream has shown the
  // same value, different from the output, for DEB consecutive samples.
  logic [1:0] m_out [2];
  logic [1:0] m_d1  [2];
  logic [1:0] m_d2  [2];
  logic [1:0] m_last[2];
  int         m_run [2];
  int         m_pend[2];
  logic       m_fault;

  always @(posedge clk) begin
    logic [1:0] raw [2];
    logic [1:0] seen;
    logic       any;
    raw[0] = A_raw;
    raw[1] = P_raw;
    cyc++;
    if (reset !== 1'b1) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_out[ch]  = 2'b00;
        m_d1[ch]   = 2'b00;
        m_d2[ch]   = 2'b00;
        m_last[ch] = 2'b00;
        m_run[ch]  = 0;
        m_pend[ch] = 0;
      end
      m_fault = 1'b0;
      exp_q.delete();
    end else begin
      any = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        seen      = m_d2[ch];
        m_d2[ch]  = m_d1[ch];
        m_d1[ch]  = raw[ch];
        m_run[ch] = (seen == m_last[ch]) ? m_run[ch] + 1 : 1;
        m_last[ch] = seen;
        if (seen != m_out[ch] && m_run[ch] >= int'(DEB)) begin
          m_out[ch] = seen;
          any = 1'b1;
        end
        // consecutive edges after which the channel is still unsettled
        m_pend[ch] = (seen != m_out[ch]) ? m_pend[ch] + 1 : 0;
`ifdef SENSOR_CHATTER_FAULT_EN
        if (m_pend[ch] >= int'(CHAT) + 1) m_fault = 1'b1;
`endif
      end
      if (any) exp_q.push_back('{cyc, m_out[0], m_out[1]});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pop on upd (or when a commit is due), otherwise outputs must hold
  always @(negedge clk) begin
    exp_t e;
    if (upd !== 1'b0 || (exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        check("upd_unexpected", 32'(upd), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("upd", 32'(upd), 32'd1);
        check("A_commit", 32'(A), 32'(e.a));
        check("P_commit", 32'(P), 32'(e.p));
      end
    end else begin
      check("A_hold", 32'(A), 32'(m_out[0]));
      check("P_hold", 32'(P), 32'(m_out[1]));
    end
    check("fault", 32'(fault), 32'(m_fault));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_A"}, 32'(A), 32'd0);
    check({tag, "_P"}, 32'(P), 32'd0);
    check({tag, "_upd"}, 32'(upd), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    A_raw = 2'b01;
    P_raw = 2'b00;
    cycles(3);
    check_reset_state("por");
    reset = 1'b1;
    cycles(12);

    // glitch of 3 cycles never reaches A
    A_raw = 2'b10; cycles(3);
    A_raw = 2'b01; cycles(12);

    // short 00 then 10: goes straight to 10
    A_raw = 2'b00; cycles(2);
    A_raw = 2'b10; cycles(12);

    // both channels commit together
    A_raw = 2'b11; P_raw = 2'b01; cycles(12);

    // P toggles every 2 cycles
    for (int i = 0; i < 20; i++) begin
      P_raw = (i % 2 == 0) ? 2'b00 : 2'b01;
      cycles(2);
    end
    cycles(10);

    // P alternates between two codes that both differ from its output
    P_raw = 2'b00; cycles(10);
    for (int i = 0; i < 30; i++) begin
      P_raw = (i % 2 == 0) ? 2'b10 : 2'b11;
      cycles(2);
    end
    reset = 1'b0; cycles(1);
    check_reset_state("chat_rst");
    reset = 1'b1; P_raw = 2'b00; cycles(12);

    // reset mid-PENDING, raw returns to 00 before release: no commit
    A_raw = 2'b01; cycles(10);
    A_raw = 2'b10; cycles(4);
    reset = 1'b0; cycles(1);
    check_reset_state("midpend");
    A_raw = 2'b00; cycles(2);
    reset = 1'b1; cycles(12);

    // reset mid-PENDING with raw still non-zero: debounces in after release
    A_raw = 2'b10; cycles(4);
    reset = 1'b0; cycles(1);
    check_reset_state("midpend2");
    reset = 1'b1; cycles(12);

    // randomized segments
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        cycles(int'($urandom_range(1, 2)));
        reset = 1'b1;
      end
      if ($urandom_range(0, 2) != 0) A_raw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) P_raw = 2'($urandom_range(0, 3));
      cycles(int'($urandom_range(1, 7)));
    end

    cycles(12);
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
